video_out_formatter: RTL and testbench
======================================

# video_out_formatter

Output stage placed directly after the display compositor. It takes the compositor's raw pixel stream (rgb, enable, vsync_start, hsync_start) and turns it into the registered, rule-conforming video bus that drives the scaler pins. Specifically it:
- retimes the whole stream by a fixed latency;
- keeps hs pulses from colliding with vs;
- inserts the end-of-line scaler-slot word;
- counts frames and lines.

## Interface
Parameters:
- SCALER_SLOT, 3'd0, scaler mode index emitted in the end-of-line word.
- LINE_WIDTH, 16, width of the line counter and the frame counter.

Ports:
- pixel_clock  in  1  pixel clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- rgb_in  in  24  compositor pixel; {R,G,B}, 8 bits each.
- enable_in  in  1  compositor active-area flag.
- vsync_start_in  in  1  single-cycle frame-start pulse.
- hsync_start_in  in  1  single-cycle line-start pulse.
- video_rgb  out  24  registered pixel or end-of-line word.
- video_de  out  1  registered data enable.
- video_vs  out  1  single-cycle vsync pulse.
- video_hs  out  1  single-cycle hsync pulse, never in the same cycle as video_vs or the cycle after it.
- line_count  out  LINE_WIDTH  number of hs pulses emitted since the last vs.
- frame_count  out  LINE_WIDTH  number of vs pulses emitted since reset; wraps.
- hs_overrun  out  1  sticky; set when an hs is dropped.

## Operation
- **Two-stage pipeline.** Stage 1 registers all inputs. Stage 2 produces the outputs.
- **video_de.** Equals enable_in delayed by 2 cycles.
- **video_rgb.**
  - When video_de = 1: the pixel delayed by 2 cycles.
  - On the first cycle with video_de = 0 after a cycle with video_de = 1: {21'd0, SCALER_SLOT}.
  - All other cycles: 24'd0.
- **video_vs.** Equals vsync_start_in delayed by 2 cycles.
- **hs collision guard.** A pending flag plus a 1-bit "vs last cycle" register.
  - A stage-1 hsync is emitted as video_hs in the next cycle only if video_vs is low in that cycle and was low in the previous cycle.
  - Otherwise the flag is set to pending. The pending hs is emitted on the first cycle that satisfies both conditions.
  - Effect: an hs that coincides with vs is emitted exactly 2 cycles later than normal.
  - If a new hsync arrives while a pulse is already pending, the new one is dropped and hs_overrun is set. hs_overrun clears only on reset.
- **Counters.**
  - line_count increments on each video_hs and resets to 0 on video_vs.
  - If vs and a pending hs would both apply, vs is applied first; the deferred hs then counts as line 1.
  - frame_count increments on each video_vs and wraps from 2^LINE_WIDTH-1 to 0.
- **State machine** (hs path):
  - IDLE: hsync arrives and the guard is clear → emit hs, stay in IDLE. Guard is blocked → go to PENDING.
  - PENDING: guard clears → emit hs, return to IDLE. Another hsync arrives → set overrun, stay in PENDING.

## Timing
- **Reset values.** While reset is high, every output and every pipeline register is 0 and the state is IDLE.
  - Reset mid-frame: any pending hs is discarded, and no end-of-line word is emitted for the truncated line.
  - The first vs seen after reset falls is handled normally.
- **Latency.** Input cycle N appears on rgb/de/vs at cycle N+2. hs appears at N+2 normally, or at N+4 when it coincides with vs.
- **No stall.** There is no back-pressure; the block accepts one pixel every cycle.
- **Edge cases.**
  - A 1-cycle DE burst still produces exactly one end-of-line word.
  - A DE that stays high through vs produces no end-of-line word.

## Configuration
- VIDEO_OUT_SCANLINES_EN defined: on odd line_count while video_de = 1, each 8-bit channel is shifted right by 1 (50 % dim). The end-of-line word and latency are unchanged.
- Not defined: pixels pass through unmodified and no extra logic is generated.

## Structure
- Shared package video_pkg holds:
  - typedef rgb_t (24-bit);
  - the end-of-line word builder constant width (3-bit slot);
  - the enum for hs guard states IDLE/PENDING.
- One sub-module, hs_guard: the pending flag, state machine and overrun flag. The top level holds the pipeline, the rgb mux, the counters and the scanline option.

## Test plan
- Pixel 24'hA1B2C3 with enable high for 4 cycles, then low; SCALER_SLOT = 3'd5 → video_rgb carries the 4 pixels at N+2..N+5, then 24'h000005 for exactly 1 cycle, then 0.
- vsync_start_in and hsync_start_in in the same cycle N → video_vs at N+2, video_hs at N+4; line_count = 1 and frame_count = 1 afterwards.
- Two hsyncs on consecutive cycles immediately after a vs → first hs deferred, second dropped, hs_overrun = 1 and stays 1 until reset.
- Run 3 frames of 512 lines → frame_count = 3 and line_count reaches 512 before each vs resets it; with LINE_WIDTH = 2, frame_count wraps 3 → 0.
- Assert reset while an hs is pending mid-line → all outputs 0 next cycle, no hs emitted, and the next frame is normal.
- With VIDEO_OUT_SCANLINES_EN, pixel 24'hFF8040 on line 1 → 24'h7F4020; on line 2 the same pixel → 24'hFF8040.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel type, end-of-line word builder and hs guard states
package video_pkg;

   typedef logic [23:0] rgb_t;

   localparam int SLOT_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } hs_state_t;

   function automatic rgb_t eol_word(input logic [SLOT_W-1:0] slot);
      return {{(24-SLOT_W){1'b0}}, slot};
   endfunction

endpackage

// File: rtl/hs_guard.sv
// rtl/hs_guard.sv - keeps hsync out of the vs cycle and the cycle after it,
// deferring at most one pulse and flagging any pulse that has to be dropped
module hs_guard import video_pkg::*; (
   input  logic clk,
   input  logic reset,
   input  logic hs_req,
   input  logic vs_next,
   output logic hs_fire,
   output logic hs,
   output logic overrun
);

   hs_state_t state;
   hs_state_t state_next;
   logic      vs_last;
   logic      guard_clear;
   logic      overrun_set;

   // vs_next is the video_vs value being registered alongside this hs decision
   assign guard_clear = !vs_next && !vs_last;

   always_comb begin
      state_next  = state;
      hs_fire     = 1'b0;
      overrun_set = 1'b0;
      case (state)
         IDLE: begin
            if (hs_req) begin
               if (guard_clear) hs_fire = 1'b1;
               else             state_next = PENDING;
            end
         end
         PENDING: begin
            if (hs_req) overrun_set = 1'b1;
            if (guard_clear) begin
               hs_fire    = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         vs_last <= 1'b0;
         hs      <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_next;
         vs_last <= vs_next;
         hs      <= hs_fire;
         if (overrun_set) overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/video_out_formatter.sv
// rtl/video_out_formatter.sv - two-stage output formatter with end-of-line slot word and
// line/frame counters; VIDEO_OUT_SCANLINES_EN enables 50% dimming of odd lines
module video_out_formatter import video_pkg::*; #(
   parameter logic [SLOT_W-1:0] SCALER_SLOT = 3'd0,
   parameter int                LINE_WIDTH  = 16
) (
   input  logic                  pixel_clock,
   input  logic                  reset,
   input  logic [23:0]           rgb_in,
   input  logic                  enable_in,
   input  logic                  vsync_start_in,
   input  logic                  hsync_start_in,
   output logic [23:0]           video_rgb,
   output logic                  video_de,
   output logic                  video_vs,
   output logic                  video_hs,
   output logic [LINE_WIDTH-1:0] line_count,
   output logic [LINE_WIDTH-1:0] frame_count,
   output logic                  hs_overrun
);

   rgb_t                  s1_rgb;
   logic                  s1_de;
   logic                  s1_vs;
   logic                  s1_hs;
   logic                  hs_fire;
   logic [LINE_WIDTH-1:0] line_next;
   rgb_t                  pixel;
   rgb_t                  rgb_next;

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         s1_rgb <= '0;
         s1_de  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_hs  <= 1'b0;
      end else begin
         s1_rgb <= rgb_in;
         s1_de  <= enable_in;
         s1_vs  <= vsync_start_in;
         s1_hs  <= hsync_start_in;
      end
   end

   hs_guard u_hs_guard (
      .clk     (pixel_clock),
      .reset   (reset),
      .hs_req  (s1_hs),
      .vs_next (s1_vs),
      .hs_fire (hs_fire),
      .hs      (video_hs),
      .overrun (hs_overrun)
   );

   // The guard never fires in a vs cycle, so the vs clear and the hs increment are exclusive
   always_comb begin
      line_next = line_count;
      if (s1_vs)        line_next = '0;
      else if (hs_fire) line_next = line_count + LINE_WIDTH'(1);
   end

`ifdef VIDEO_OUT_SCANLINES_EN
   assign pixel = line_next[0] ? {1'b0, s1_rgb[23:17], 1'b0, s1_rgb[15:9], 1'b0, s1_rgb[7:1]}
                               : s1_rgb;
`else
   assign pixel = s1_rgb;
`endif

   always_comb begin
      rgb_next = '0;
      if (s1_de)         rgb_next = pixel;
      else if (video_de) rgb_next = eol_word(SCALER_SLOT);
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         video_rgb   <= '0;
         video_de    <= 1'b0;
         video_vs    <= 1'b0;
         line_count  <= '0;
         frame_count <= '0;
      end else begin
         video_rgb  <= rgb_next;
         video_de   <= s1_de;
         video_vs   <= s1_vs;
         line_count <= line_next;
         if (s1_vs) frame_count <= frame_count + LINE_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_video_out_formatter.sv
// tb/tb_video_out_formatter.sv - table-driven and randomized checks of video_out_formatter
module tb_video_out_formatter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [23:0] rgb_in;
   logic        enable_in;
   logic        vsync_start_in;
   logic        hsync_start_in;

   logic [23:0] video_rgb;
   logic        video_de, video_vs, video_hs, hs_overrun;
   logic [15:0] line_count, frame_count;

   logic [23:0] s_rgb;
   logic        s_de, s_vs, s_hs, s_ovr;
   logic [1:0]  s_lc, s_fc;

   video_out_formatter #(.SCALER_SLOT(3'd5), .LINE_WIDTH(16)) dut (
      .pixel_clock(clk), .reset(reset), .rgb_in(rgb_in), .enable_in(enable_in),
      .vsync_start_in(vsync_start_in), .hsync_start_in(hsync_start_in),
      .video_rgb(video_rgb), .video_de(video_de), .video_vs(video_vs), .video_hs(video_hs),
      .line_count(line_count), .frame_count(frame_count), .hs_overrun(hs_overrun)
   );

   video_out_formatter #(.SCALER_SLOT(3'd0), .LINE_WIDTH(2)) dut_small (
      .pixel_clock(clk), .reset(reset), .rgb_in(rgb_in), .enable_in(enable_in),
      .vsync_start_in(vsync_start_in), .hsync_start_in(hsync_start_in),
      .video_rgb(s_rgb), .video_de(s_de), .video_vs(s_vs), .video_hs(s_hs),
      .line_count(s_lc), .frame_count(s_fc), .hs_overrun(s_ovr)
   );

`ifdef VIDEO_OUT_SCANLINES_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   typedef struct packed {
      logic        rst, en, vs, hs;
      logic [23:0] px;
   } in_t;

   typedef struct {
      logic        rst, en, vs, hs;
      logic [23:0] px;
      logic        chk;
      logic [23:0] x_rgb;
      logic        x_de, x_vs, x_hs;
   } row_t;

   int n_checks = 0;
   int n_fail   = 0;

   in_t         h1, h2;
   logic        m_pending, m_ovr, m_prev_de, m_prev_vs;
   int          m_lc, m_fc;
   logic [23:0] e_rgb, e_rgb_s;
   logic        e_de, e_vs, e_hs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for this cycle from the inputs applied two cycles earlier
   task automatic model_step();
      in_t  d;
      logic allowed;
      e_hs = 1'b0;
      if (h1.rst) begin
         m_pending = 0; m_ovr = 0; m_lc = 0; m_fc = 0; m_prev_de = 0; m_prev_vs = 0;
         e_rgb = '0; e_rgb_s = '0; e_de = 0; e_vs = 0;
      end else begin
         d       = h2;
         e_de    = d.en;
         e_vs    = d.vs;
         allowed = !e_vs && !m_prev_vs;
         if (m_pending) begin
            if (d.hs) m_ovr = 1'b1;
            if (allowed) begin e_hs = 1'b1; m_pending = 1'b0; end
         end else if (d.hs) begin
            if (allowed) e_hs = 1'b1;
            else         m_pending = 1'b1;
         end
         if (e_vs)      begin m_lc = 0; m_fc++; end
         else if (e_hs) m_lc++;
         if (e_de) begin
            e_rgb = d.px;
            if (SCAN && (m_lc % 2 == 1))
               e_rgb = {d.px[23:16] >> 1, d.px[15:8] >> 1, d.px[7:0] >> 1};
            e_rgb_s = e_rgb;
         end else if (m_prev_de) begin
            e_rgb = 24'h000005; e_rgb_s = 24'h000000;
         end else begin
            e_rgb = '0; e_rgb_s = '0;
         end
         m_prev_de = e_de;
         m_prev_vs = e_vs;
      end
   endtask

   task automatic tick(input row_t r);
      @(negedge clk);
      model_step();
      chk("video_rgb",   32'(video_rgb),   32'(e_rgb));
      chk("video_de",    32'(video_de),    32'(e_de));
      chk("video_vs",    32'(video_vs),    32'(e_vs));
      chk("video_hs",    32'(video_hs),    32'(e_hs));
      chk("line_count",  32'(line_count),  m_lc % 65536);
      chk("frame_count", 32'(frame_count), m_fc % 65536);
      chk("hs_overrun",  32'(hs_overrun),  32'(m_ovr));
      chk("w2_rgb",      32'(s_rgb),       32'(e_rgb_s));
      chk("w2_de",       32'(s_de),        32'(e_de));
      chk("w2_vs",       32'(s_vs),        32'(e_vs));
      chk("w2_hs",       32'(s_hs),        32'(e_hs));
      chk("w2_line",     32'(s_lc),        m_lc % 4);
      chk("w2_frame",    32'(s_fc),        m_fc % 4);
      chk("w2_overrun",  32'(s_ovr),       32'(m_ovr));
      if (r.chk) begin
         chk("tbl_rgb", 32'(video_rgb), 32'(r.x_rgb));
         chk("tbl_de",  32'(video_de),  32'(r.x_de));
         chk("tbl_vs",  32'(video_vs),  32'(r.x_vs));
         chk("tbl_hs",  32'(video_hs),  32'(r.x_hs));
      end
      reset          = r.rst;
      enable_in      = r.en;
      vsync_start_in = r.vs;
      hsync_start_in = r.hs;
      rgb_in         = r.px;
      h2     = h1;
      h1.rst = r.rst;
      h1.en  = r.en & ~r.rst;
      h1.vs  = r.vs & ~r.rst;
      h1.hs  = r.hs & ~r.rst;
      h1.px  = r.rst ? 24'h0 : r.px;
   endtask

   function automatic row_t mk(input logic r, e, v, hh, input logic [23:0] p,
                               input logic c, input logic [23:0] xr, input logic xd, xv, xh);
      row_t x;
      x.rst = r; x.en = e; x.vs = v; x.hs = hh; x.px = p;
      x.chk = c; x.x_rgb = xr; x.x_de = xd; x.x_vs = xv; x.x_hs = xh;
      return x;
   endfunction

   task automatic drive(input logic r, e, v, hh, input logic [23:0] p);
      tick(mk(r, e, v, hh, p, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic run_tbl(input row_t t[$]);
      foreach (t[i]) tick(t[i]);
   endtask

   task automatic run_line();
      drive(0, 0, 0, 1, 24'h0);
      drive(0, 1, 0, 0, 24'($urandom()));
      drive(0, 1, 0, 0, 24'($urandom()));
      drive(0, 0, 0, 0, 24'h0);
   endtask

   localparam logic [23:0] EXP_LINE1 = SCAN ? 24'h7F4020 : 24'hFF8040;

   initial begin
      row_t tbl[$];

      reset = 1'b1; enable_in = 0; vsync_start_in = 0; hsync_start_in = 0; rgb_in = '0;
      h1 = '0; h1.rst = 1'b1; h2 = '0;
      m_pending = 0; m_ovr = 0; m_prev_de = 0; m_prev_vs = 0; m_lc = 0; m_fc = 0;

      drive(1, 0, 0, 0, 24'h0);
      drive(1, 1, 1, 1, 24'hFFFFFF);
      repeat (3) drive(0, 0, 0, 0, 24'h0);

      // 4-pixel burst then a 1-cycle burst, each closed by one end-of-line word
      tbl = {};
      tbl.push_back(mk(0,1,0,0,24'hA1B2C3, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,1,0,0,24'hA1B2C3, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,1,0,0,24'hA1B2C3, 1,24'hA1B2C3,1,0,0));
      tbl.push_back(mk(0,1,0,0,24'hA1B2C3, 1,24'hA1B2C3,1,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'hA1B2C3,1,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'hA1B2C3,1,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000005,0,0,0));
      tbl.push_back(mk(0,1,0,0,24'h123456, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h123456,1,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000005,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000000,0,0,0));
      run_tbl(tbl);

      // vs+hs in one cycle: hs two cycles late
      tbl = {};
      tbl.push_back(mk(0,0,1,1,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,1,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,1));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      run_tbl(tbl);
      chk("collision_line_count",  32'(line_count),  32'd1);
      chk("collision_frame_count", 32'(frame_count), 32'd1);

      // two hsyncs right after vs: first deferred, second dropped
      tbl = {};
      tbl.push_back(mk(0,0,1,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,1,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,1,24'h0, 1,24'h0,0,1,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,1));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      run_tbl(tbl);
      chk("overrun_set",        32'(hs_overrun),  32'd1);
      chk("overrun_line_count", 32'(line_count),  32'd1);
      chk("overrun_frame",      32'(frame_count), 32'd2);
      repeat (20) drive(0, 1'($urandom_range(0, 1)), 0, 0, 24'($urandom()));
      chk("overrun_sticky", 32'(hs_overrun), 32'd1);

      // reset while an hs is pending
      tbl = {};
      tbl.push_back(mk(0,0,0,0,24'h0, 0,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 0,24'h0,0,0,0));
      tbl.push_back(mk(0,0,1,1,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(1,0,0,0,24'h0, 1,24'h0,0,1,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h0, 1,24'h0,0,0,0));
      run_tbl(tbl);
      chk("rst_pending_line",    32'(line_count),  32'd0);
      chk("rst_pending_frame",   32'(frame_count), 32'd0);
      chk("rst_pending_overrun", 32'(hs_overrun),  32'd0);
      drive(0, 0, 1, 0, 24'h0);
      repeat (2) drive(0, 0, 0, 0, 24'h0);
      repeat (3) run_line();
      repeat (2) drive(0, 0, 0, 0, 24'h0);
      chk("after_rst_line",  32'(line_count),  32'd3);
      chk("after_rst_frame", 32'(frame_count), 32'd1);

      // scanline behaviour on line 1 and line 2
      tbl = {};
      tbl.push_back(mk(0,0,1,0,24'h000000, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,0,0,1,24'h000000, 1,24'h000000,0,1,0));
      tbl.push_back(mk(0,1,0,0,24'hFF8040, 1,24'h000000,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000000,0,0,1));
      tbl.push_back(mk(0,0,0,1,24'h000000, 1,EXP_LINE1, 1,0,0));
      tbl.push_back(mk(0,1,0,0,24'hFF8040, 1,24'h000005,0,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000000,0,0,1));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'hFF8040,1,0,0));
      tbl.push_back(mk(0,0,0,0,24'h000000, 1,24'h000005,0,0,0));
      run_tbl(tbl);

      // 512-line frames from a clean reset; 2-bit frame counter wraps on the 4th vs
      drive(1, 0, 0, 0, 24'h0);
      drive(0, 0, 0, 0, 24'h0);
      for (int f = 0; f < 3; f++) begin
         drive(0, 0, 1, 0, 24'h0);
         repeat (2) drive(0, 0, 0, 0, 24'h0);
         repeat (512) run_line();
         repeat (3) drive(0, 0, 0, 0, 24'h0);
         chk("lines_before_vs", 32'(line_count), 32'd512);
      end
      chk("frames_3",      32'(frame_count), 32'd3);
      chk("frames_3_w2",   32'(s_fc),        32'd3);
      drive(0, 0, 1, 0, 24'h0);
      repeat (3) drive(0, 0, 0, 0, 24'h0);
      chk("frames_4",      32'(frame_count), 32'd4);
      chk("frames_wrap_w2", 32'(s_fc),       32'd0);
      chk("line_reset_vs", 32'(line_count),  32'd0);

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 199) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 7) == 0,
               24'($urandom()));
      end
      repeat (4) drive(0, 0, 0, 0, 24'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
